park_pass_entry: RTL and testbench

Upstream input stage for the parking-gate controller. It debounces a raw "enter" push-button and sequences two 2-bit digit entries taken from switches. It then presents the stable pair on password_1/password_2, with a valid flag, for the gate controller's password comparison. A partial entry is discarded after a timeout, and a completed entry is held until it is cleared or overwritten.

---
 rtl/park_pass_entry.sv | 184 ++++++++++++++++++
 tb/tb_park_pass_entry.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/park_pass_entry.sv
// park_pass_entry
// Input stage for the parking-gate controller. Debounces the raw "enter"
// push-button, collects two CODE_W-bit digits from the switches and presents
// them as a stable password pair for the gate controller.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous reset, active-high
//   key_in         raw asynchronous push-button, high = pressed
//   key_val        digit value from switches, sampled when a press is taken
//   clear_in       synchronous clear of the current entry
//   password_1     first entered digit (registered)
//   password_2     second entered digit (registered)
//   pass_valid     high while both digits are held
//   digit_cnt      number of digits held: 0, 1 or 2
//   entry_timeout  one-cycle pulse when an entry is discarded by a timer
//
// Optional feature macro: PARK_PASS_ENTRY_AUTOCLR_EN
//   When defined, a completed entry left untouched for ENTRY_TIMEOUT cycles
//   clears itself and pulses entry_timeout. When undefined, a completed entry
//   is held until cleared or overwritten.
//
// FSM states:
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_EMPTY  | no digits held, waiting for first press
//   S_DIGIT1 | first digit held, entry timer running
//   S_FULL   | both digits held, pass_valid high

module park_pass_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ENTRY_TIMEOUT   = 64,
    parameter int CODE_W          = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_in,
    input  logic [CODE_W-1:0] key_val,
    input  logic              clear_in,
    output logic [CODE_W-1:0] password_1,
    output logic [CODE_W-1:0] password_2,
    output logic              pass_valid,
    output logic [1:0]        digit_cnt,
    output logic              entry_timeout
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = $clog2(ENTRY_TIMEOUT);

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(ENTRY_TIMEOUT - 1);

    localparam logic [1:0] S_EMPTY  = 2'd0;
    localparam logic [1:0] S_DIGIT1 = 2'd1;
    localparam logic [1:0] S_FULL   = 2'd2;

    logic          sync_1;
    logic          sync_2;
    logic [DW-1:0] db_cnt;
    logic          db_level;
    logic          db_level_d;
    logic          press;

    logic [1:0]    state;
    logic [TW-1:0] tmo_cnt;

`ifdef PARK_PASS_ENTRY_AUTOCLR_EN
    logic [TW-1:0] full_cnt;
`endif

    // Synchroniser and debounce: the debounced level only follows the
    // synced input after DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            db_cnt     <= '0;
            db_level   <= 1'b0;
            db_level_d <= 1'b0;
        end else begin
            sync_1     <= key_in;
            sync_2     <= sync_1;
            db_level_d <= db_level;
            if (sync_2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync_2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    // Single-cycle press on the debounced rising edge; release is ignored.
    assign press = db_level & ~db_level_d;

    // Timers are down-counters: loaded with ENTRY_TIMEOUT-1 on entry to the
    // timed state, expiring on the edge where they read zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_EMPTY;
            password_1    <= '0;
            password_2    <= '0;
            pass_valid    <= 1'b0;
            digit_cnt     <= 2'd0;
            entry_timeout <= 1'b0;
            tmo_cnt       <= '0;
`ifdef PARK_PASS_ENTRY_AUTOCLR_EN
            full_cnt      <= '0;
`endif
        end else begin
            entry_timeout <= 1'b0;
            if (clear_in) begin
                // A press on the same edge is dropped.
                state      <= S_EMPTY;
                password_1 <= '0;
                password_2 <= '0;
                pass_valid <= 1'b0;
                digit_cnt  <= 2'd0;
            end else if (press) begin
                case (state)
                    S_DIGIT1: begin
                        // Press wins over a timer expiring on this edge.
                        state      <= S_FULL;
                        password_2 <= key_val;
                        pass_valid <= 1'b1;
                        digit_cnt  <= 2'd2;
`ifdef PARK_PASS_ENTRY_AUTOCLR_EN
                        full_cnt   <= TMO_LOAD;
`endif
                    end
                    default: begin
                        // From EMPTY or FULL: start a fresh entry.
                        state      <= S_DIGIT1;
                        password_1 <= key_val;
                        password_2 <= '0;
                        pass_valid <= 1'b0;
                        digit_cnt  <= 2'd1;
                        tmo_cnt    <= TMO_LOAD;
                    end
                endcase
            end else begin
                case (state)
                    S_DIGIT1: begin
                        if (tmo_cnt == '0) begin
                            state         <= S_EMPTY;
                            password_1    <= '0;
                            digit_cnt     <= 2'd0;
                            entry_timeout <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt - TW'(1);
                        end
                    end
`ifdef PARK_PASS_ENTRY_AUTOCLR_EN
                    S_FULL: begin
                        if (full_cnt == '0) begin
                            state         <= S_EMPTY;
                            password_1    <= '0;
                            password_2    <= '0;
                            pass_valid    <= 1'b0;
                            digit_cnt     <= 2'd0;
                            entry_timeout <= 1'b1;
                        end else begin
                            full_cnt <= full_cnt - TW'(1);
                        end
                    end
`else
                    S_FULL: begin
                        state <= S_FULL;
                    end
`endif
                    S_EMPTY: begin
                        state <= S_EMPTY;
                    end
                    default: begin
                        state <= S_EMPTY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_park_pass_entry.sv
// tb_park_pass_entry
// Directed stimulus for park_pass_entry with a spec-level model that is
// compared against the DUT after every clock edge, plus literal checks at
// key points of each scenario.
// Optional feature macro observed: PARK_PASS_ENTRY_AUTOCLR_EN.

module tb_park_pass_entry;

    localparam int DC = 4;
    localparam int ET = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_in;
    logic [1:0] key_val;
    logic       clear_in;
    logic [1:0] password_1;
    logic [1:0] password_2;
    logic       pass_valid;
    logic [1:0] digit_cnt;
    logic       entry_timeout;

    int checks = 0;
    int errors = 0;

    park_pass_entry #(
        .DEBOUNCE_CYCLES(DC),
        .ENTRY_TIMEOUT  (ET),
        .CODE_W         (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_in       (key_in),
        .key_val      (key_val),
        .clear_in     (clear_in),
        .password_1   (password_1),
        .password_2   (password_2),
        .pass_valid   (pass_valid),
        .digit_cnt    (digit_cnt),
        .entry_timeout(entry_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: key history (m_hist[0] = key_in sampled at the latest edge),
    // debounced level flips once the synced samples seen by the last DC
    // edges all disagree with it; a rise is acted on one edge later.
    bit m_hist [0:DC];
    bit m_db;
    bit m_pend;
    int m_st;      // 0 empty, 1 one digit, 2 two digits
    int m_edge = 0;
    int m_mark;    // edge on which the current state was entered
    int m_p1, m_p2, m_pv, m_dcnt, m_to;

    always @(posedge clk) begin
        bit press_now;
        bit flip;
        #1;
        m_edge++;
        if (reset) begin
            for (int i = 0; i <= DC; i++) m_hist[i] = 1'b0;
            m_db = 1'b0; m_pend = 1'b0; m_st = 0; m_mark = m_edge;
            m_p1 = 0; m_p2 = 0; m_pv = 0; m_dcnt = 0; m_to = 0;
        end else begin
            press_now = m_pend;
            m_pend = 1'b0;
            flip = 1'b1;
            for (int i = 1; i <= DC; i++) if (m_hist[i] == m_db) flip = 1'b0;
            if (flip) begin
                m_db = ~m_db;
                if (m_db) m_pend = 1'b1;
            end
            for (int i = DC; i >= 1; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = key_in;

            m_to = 0;
            if (clear_in) begin
                m_p1 = 0; m_p2 = 0; m_pv = 0; m_dcnt = 0; m_st = 0;
            end else if (press_now) begin
                if (m_st == 1) begin
                    m_p2 = int'(key_val); m_pv = 1; m_dcnt = 2; m_st = 2;
                end else begin
                    m_p1 = int'(key_val); m_p2 = 0; m_pv = 0; m_dcnt = 1; m_st = 1;
                end
                m_mark = m_edge;
            end else if (m_st == 1 && (m_edge - m_mark) == ET) begin
                m_p1 = 0; m_dcnt = 0; m_to = 1; m_st = 0;
            end
`ifdef PARK_PASS_ENTRY_AUTOCLR_EN
            else if (m_st == 2 && (m_edge - m_mark) == ET) begin
                m_p1 = 0; m_p2 = 0; m_pv = 0; m_dcnt = 0; m_to = 1; m_st = 0;
            end
`endif
        end
        chk("cmp_password_1", int'(password_1), m_p1);
        chk("cmp_password_2", int'(password_2), m_p2);
        chk("cmp_pass_valid", int'(pass_valid), m_pv);
        chk("cmp_digit_cnt", int'(digit_cnt), m_dcnt);
        chk("cmp_entry_timeout", int'(entry_timeout), m_to);
    end

    // Press acted on 6 edges after the first high sample; released after
    // 7 cycles and idle 7 more, so consecutive presses are 14 edges apart.
    task automatic do_press(input logic [1:0] v);
        key_val = v;
        key_in  = 1'b1;
        repeat (7) @(negedge clk);
        key_in  = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pulses;
        reset = 1'b1; key_in = 1'b0; key_val = 2'b00; clear_in = 1'b0;

        // 1. reset
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_password_1", int'(password_1), 0);
        chk("rst_password_2", int'(password_2), 0);
        chk("rst_pass_valid", int'(pass_valid), 0);
        chk("rst_digit_cnt", int'(digit_cnt), 0);

        // 2. first press lands on edge 7, then second digit
        key_val = 2'b01;
        key_in  = 1'b1;
        n = 0;
        while (digit_cnt != 2'd1 && n < 20) begin
            @(posedge clk); n++; #1;
        end
        chk("press_latency_edges", n, 7);
        chk("first_password_1", int'(password_1), 1);
        @(negedge clk);
        key_in = 1'b0;
        repeat (6) @(negedge clk);
        do_press(2'b10);
        chk("second_password_1", int'(password_1), 1);
        chk("second_password_2", int'(password_2), 2);
        chk("second_pass_valid", int'(pass_valid), 1);
        chk("second_digit_cnt", int'(digit_cnt), 2);

        // 3. short glitch, then bounce before a steady press
        do_clear();
        key_val = 2'b10;
        key_in = 1'b1;
        repeat (3) @(negedge clk);
        key_in = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_digit_cnt", int'(digit_cnt), 0);
        key_in = 1'b1; @(negedge clk);
        key_in = 1'b0; @(negedge clk);
        key_in = 1'b1; @(negedge clk);
        key_in = 1'b0; @(negedge clk);
        key_in = 1'b1;
        repeat (8) @(negedge clk);
        key_in = 1'b0;
        repeat (7) @(negedge clk);
        chk("bounce_digit_cnt", int'(digit_cnt), 1);
        chk("bounce_password_1", int'(password_1), 2);

        // 4a. one digit, then idle until timeout
        do_clear();
        repeat (2) @(negedge clk);
        key_val = 2'b11;
        key_in = 1'b1;
        n = 0;
        while (digit_cnt != 2'd1 && n < 20) begin
            @(negedge clk); n++;
        end
        chk("t4_enter_digit_cnt", int'(digit_cnt), 1);
        key_in = 1'b0;
        pulses = 0;
        repeat (ET) begin
            @(negedge clk);
            if (entry_timeout) pulses++;
        end
        chk("timeout_pulse_seen", int'(entry_timeout), 1);
        chk("timeout_pulse_count", pulses, 1);
        chk("timeout_password_1", int'(password_1), 0);
        chk("timeout_digit_cnt", int'(digit_cnt), 0);
        @(negedge clk);
        chk("timeout_pulse_width", int'(entry_timeout), 0);

        // 4b. second press acted on exactly the expiry edge
        repeat (4) @(negedge clk);
        key_in = 1'b1;
        n = 0;
        while (digit_cnt != 2'd1 && n < 20) begin
            @(negedge clk); n++;
        end
        chk("t4b_enter_digit_cnt", int'(digit_cnt), 1);
        key_in = 1'b0;
        repeat (9) @(negedge clk);
        key_in = 1'b1;
        pulses = 0;
        repeat (7) begin
            @(negedge clk);
            if (entry_timeout) pulses++;
        end
        key_in = 1'b0;
        chk("expiry_press_digit_cnt", int'(digit_cnt), 2);
        chk("expiry_press_pass_valid", int'(pass_valid), 1);
        chk("expiry_press_no_pulse", pulses, 0);
        repeat (10) @(negedge clk);

        // 5. clear on the press edge, then overwrite from FULL
        do_clear();
        do_press(2'b01);
        do_press(2'b10);
        chk("full_pass_valid", int'(pass_valid), 1);
        key_val = 2'b11;
        key_in = 1'b1;
        repeat (6) @(negedge clk);
        clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        chk("clear_password_1", int'(password_1), 0);
        chk("clear_password_2", int'(password_2), 0);
        chk("clear_pass_valid", int'(pass_valid), 0);
        chk("clear_digit_cnt", int'(digit_cnt), 0);
        key_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("clear_press_dropped", int'(digit_cnt), 0);
        do_press(2'b01);
        do_press(2'b10);
        do_press(2'b11);
        chk("overwrite_password_1", int'(password_1), 3);
        chk("overwrite_password_2", int'(password_2), 0);
        chk("overwrite_pass_valid", int'(pass_valid), 0);
        chk("overwrite_digit_cnt", int'(digit_cnt), 1);

        // 6. reset mid-entry, then FULL hold / auto-clear
        do_clear();
        key_val = 2'b01;
        key_in = 1'b1;
        repeat (8) @(negedge clk);
        key_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_digit_cnt", int'(digit_cnt), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_password_1", int'(password_1), 0);
        chk("midrst_digit_cnt", int'(digit_cnt), 0);
        chk("midrst_entry_timeout", int'(entry_timeout), 0);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (entry_timeout) pulses++;
        end
        chk("midrst_no_pulse", pulses, 0);

        do_press(2'b01);
        do_press(2'b10);
        chk("hold_pass_valid", int'(pass_valid), 1);
`ifdef PARK_PASS_ENTRY_AUTOCLR_EN
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (entry_timeout) pulses++;
        end
        chk("autoclr_pulse_count", pulses, 1);
        chk("autoclr_digit_cnt", int'(digit_cnt), 0);
        chk("autoclr_pass_valid", int'(pass_valid), 0);
        chk("autoclr_password_2", int'(password_2), 0);
`else
        repeat (100) @(negedge clk);
        chk("hold_after_100_pass_valid", int'(pass_valid), 1);
        chk("hold_after_100_digit_cnt", int'(digit_cnt), 2);
        chk("hold_after_100_password_1", int'(password_1), 1);
        chk("hold_after_100_password_2", int'(password_2), 2);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
